// File: rtl/ko_operand_split_buf.sv
// rtl/ko_operand_split_buf.sv - Karatsuba operand limb splitter with pair sums and 2-entry output buffer
module ko_operand_split_buf #(
  parameter int DATA_WIDTH   = 72,
  parameter int KO_PARAMETER = 4,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_sq,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a_limbs,
  output logic [DATA_WIDTH-1:0] out_b_limbs,
  output logic [KO_PARAMETER*(KO_PARAMETER-1)/2*(DATA_WIDTH/KO_PARAMETER+1)-1:0] out_a_psum,
  output logic [KO_PARAMETER*(KO_PARAMETER-1)/2*(DATA_WIDTH/KO_PARAMETER+1)-1:0] out_b_psum,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_sq
);

  localparam int L  = DATA_WIDTH / KO_PARAMETER;
  localparam int NP = KO_PARAMETER * (KO_PARAMETER - 1) / 2;
  localparam int PW = NP * (L + 1);
  localparam int EW = 2 * DATA_WIDTH + 2 * PW + TAG_WIDTH + 1;

  if ((DATA_WIDTH % KO_PARAMETER) != 0 || KO_PARAMETER < 2) begin : g_bad_param
    $error("ko_operand_split_buf: DATA_WIDTH must be divisible by KO_PARAMETER >= 2");
  end

  logic [DATA_WIDTH-1:0] b_src;
  logic [PW-1:0]         psum_a;
  logic [PW-1:0]         psum_b;

  // Squaring mode reuses a for the b side, so b sums fall out of the same adders' inputs.
  assign b_src = in_sq ? in_a : in_b;

  for (genvar gi = 0; gi < KO_PARAMETER; gi++) begin : g_i
    for (genvar gj = gi + 1; gj < KO_PARAMETER; gj++) begin : g_j
      localparam int K = gi * KO_PARAMETER - gi * (gi + 1) / 2 + (gj - gi - 1);
      assign psum_a[K*(L+1) +: L+1] = {1'b0, in_a[gi*L +: L]}  + {1'b0, in_a[gj*L +: L]};
      assign psum_b[K*(L+1) +: L+1] = {1'b0, b_src[gi*L +: L]} + {1'b0, b_src[gj*L +: L]};
    end
  end

  logic [EW-1:0] mem [2];
  logic [EW-1:0] entry;
  logic [1:0]    cnt;
  logic          head;
  logic          tail;
  logic          push;
  logic          pop;

  assign entry     = {in_a, b_src, psum_a, psum_b, in_tag, in_sq};
  assign in_ready  = (cnt != 2'd2) & ~rst;
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign tail      = head ^ cnt[0];

  // A popped slot is cleared so an empty buffer always presents zeros at the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      head   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (pop) begin
        mem[head] <= '0;
        head      <= ~head;
      end
      if (push) begin
        mem[tail] <= entry;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign {out_a_limbs, out_b_limbs, out_a_psum, out_b_psum, out_tag, out_sq} = mem[head];

endmodule

// File: tb/tb_ko_operand_split_buf.sv
// tb/tb_ko_operand_split_buf.sv - self-checking bench for ko_operand_split_buf
module tb_ko_operand_split_buf;

  localparam int DW = 72;
  localparam int PW = 114;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_sq = 1'b0;
  logic [3:0]    in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_a_limbs;
  logic [DW-1:0] out_b_limbs;
  logic [PW-1:0] out_a_psum;
  logic [PW-1:0] out_b_psum;
  logic [3:0]    out_tag;
  logic          out_sq;

  ko_operand_split_buf #(.DATA_WIDTH(72), .KO_PARAMETER(4), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sq(in_sq), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a_limbs(out_a_limbs), .out_b_limbs(out_b_limbs),
    .out_a_psum(out_a_psum), .out_b_psum(out_b_psum),
    .out_tag(out_tag), .out_sq(out_sq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sq;
    logic [3:0]    tag;
  } ent_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sq;
    logic [3:0]    tag;
    logic [DW-1:0] exp_al;
    logic [DW-1:0] exp_bl;
    logic [PW-1:0] exp_ap;
    logic [PW-1:0] exp_bp;
  } vec_t;

  ent_t mq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_psum(input logic [DW-1:0] x);
    logic [PW-1:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        r[k*19 +: 19] = {1'b0, x[i*18 +: 18]} + {1'b0, x[j*18 +: 18]};
        k++;
      end
    end
    return r;
  endfunction

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({pfx, "_a_limbs"},   128'(out_a_limbs), 128'd0);
    chk({pfx, "_b_limbs"},   128'(out_b_limbs), 128'd0);
    chk({pfx, "_a_psum"},    128'(out_a_psum), 128'd0);
    chk({pfx, "_b_psum"},    128'(out_b_psum), 128'd0);
    chk({pfx, "_tag"},       128'(out_tag), 128'd0);
    chk({pfx, "_sq"},        128'(out_sq), 128'd0);
  endtask

  // Called at a negedge with inputs already driven: checks the head against the model,
  // predicts the transfers of the next rising edge, then advances to the next negedge.
  task automatic step(output bit pushed);
    ent_t e;
    bit   pop;
    bit   push;
    logic [DW-1:0] eb;
    if (mq.size() == 0) begin
      chk_zero_outputs("empty");
    end else begin
      e  = mq[0];
      eb = e.sq ? e.a : e.b;
      chk("head_valid",   128'(out_valid), 128'd1);
      chk("head_a_limbs", 128'(out_a_limbs), 128'(e.a));
      chk("head_b_limbs", 128'(out_b_limbs), 128'(eb));
      chk("head_a_psum",  128'(out_a_psum), 128'(ref_psum(e.a)));
      chk("head_b_psum",  128'(out_b_psum), 128'(ref_psum(eb)));
      chk("head_tag",     128'(out_tag), 128'(e.tag));
      chk("head_sq",      128'(out_sq), 128'(e.sq));
    end
    chk("in_ready", 128'(in_ready), 128'(mq.size() != 2));
    pop  = out_valid && out_ready;
    push = in_valid && in_ready;
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (push) begin
      if (mq.size() >= 2) chk("overflow_cnt", 128'(mq.size()), 128'd1);
      e.a = in_a; e.b = in_b; e.sq = in_sq; e.tag = in_tag;
      mq.push_back(e);
    end
    pushed = push;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[3];
  bit   p;
  int   idx;
  int   npush;

  initial begin
    vecs[0] = '{a: 72'h1, b: {72{1'b1}}, sq: 1'b0, tag: 4'd3,
                exp_al: 72'h1, exp_bl: {72{1'b1}},
                exp_ap: {19'd0, 19'd0, 19'd0, 19'd1, 19'd1, 19'd1},
                exp_bp: {6{19'h7FFFE}}};
    vecs[1] = '{a: 72'h3FFFF, b: 72'h5, sq: 1'b1, tag: 4'd5,
                exp_al: 72'h3FFFF, exp_bl: 72'h3FFFF,
                exp_ap: {19'd0, 19'd0, 19'd0, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF},
                exp_bp: {19'd0, 19'd0, 19'd0, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF}};
    vecs[2] = '{a: {18'd4, 18'd3, 18'd2, 18'd1}, b: 72'h0, sq: 1'b0, tag: 4'd9,
                exp_al: {18'd4, 18'd3, 18'd2, 18'd1}, exp_bl: 72'h0,
                exp_ap: {19'd7, 19'd6, 19'd5, 19'd5, 19'd4, 19'd3},
                exp_bp: '0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk_zero_outputs("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Directed vectors, one at a time, with one-cycle latency
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1;
      in_a = vecs[v].a; in_b = vecs[v].b; in_sq = vecs[v].sq; in_tag = vecs[v].tag;
      step(p);
      in_valid = 1'b0;
      chk("vec_valid",   128'(out_valid), 128'd1);
      chk("vec_a_limbs", 128'(out_a_limbs), 128'(vecs[v].exp_al));
      chk("vec_b_limbs", 128'(out_b_limbs), 128'(vecs[v].exp_bl));
      chk("vec_a_psum",  128'(out_a_psum), 128'(vecs[v].exp_ap));
      chk("vec_b_psum",  128'(out_b_psum), 128'(vecs[v].exp_bp));
      chk("vec_tag",     128'(out_tag), 128'(vecs[v].tag));
      chk("vec_sq",      128'(out_sq), 128'(vecs[v].sq));
      step(p);
    end
    step(p);

    // Backpressure: tags 1,2,3 offered with the sink stalled
    out_ready = 1'b0;
    in_sq = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3);
      in_tag = 4'(idx + 1);
      in_a = {$urandom, $urandom, $urandom};
      in_b = {$urandom, $urandom, $urandom};
      step(p);
      if (p) idx++;
    end
    chk("bp_accepted_while_stalled", 128'(idx), 128'd2);
    chk("bp_in_ready_low", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 3);
      in_tag = 4'(idx + 1);
      step(p);
      if (p) idx++;
    end
    chk("bp_all_accepted", 128'(idx), 128'd3);

    // Streaming at full rate
    npush = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1;
      in_a = {$urandom, $urandom, $urandom};
      in_b = {$urandom, $urandom, $urandom};
      in_sq = ($urandom_range(3) == 0);
      in_tag = 4'($urandom);
      step(p);
      if (p) npush++;
    end
    in_valid = 1'b0;
    chk("stream_pushes", 128'(npush), 128'd100);
    step(p);
    step(p);

    // Random valid/ready toggling
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      in_a = {$urandom, $urandom, $urandom};
      in_b = {$urandom, $urandom, $urandom};
      in_sq = 1'($urandom);
      in_tag = 4'($urandom);
      step(p);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step(p);

    // Reset with a full buffer
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_tag = 4'(c + 4);
      in_a = {$urandom, $urandom, $urandom};
      step(p);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("mid_rst");
    chk("mid_rst_held_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", 128'(in_ready), 128'd1);
    mq.delete();
    in_valid = 1'b1;
    in_tag = 4'hA;
    in_a = 72'h123456789ABCDEF012;
    in_b = 72'h0FEDCBA9876543210F;
    in_sq = 1'b0;
    out_ready = 1'b1;
    step(p);
    in_valid = 1'b0;
    chk("after_rst_first_tag", 128'(out_tag), 128'hA);
    step(p);
    step(p);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ko_operand_split_buf.md
Name: ko_operand_split_buf

Overview:
- Parametrised, buffered successor to the Karatsuba operand splitter.
- Accepts operand pairs (a, b) of DATA_WIDTH bits over a valid/ready handshake and splits each operand into KO_PARAMETER equal limbs.
- Also precomputes all Karatsuba pairwise limb sums (m_i + m_j, i<j) for both operands.
- Presents the results from a 2-entry output buffer to the downstream KO partial-product multipliers, with full-throughput streaming and registered backpressure.

Parameters:
- DATA_WIDTH, 72, operand width; must be divisible by KO_PARAMETER (elaboration error otherwise).
- KO_PARAMETER, 4, number of limbs per operand (>=2).
- TAG_WIDTH, 4, sideband tag carried with each operand pair.
- Derived: L = DATA_WIDTH/KO_PARAMETER; NP = KO_PARAMETER*(KO_PARAMETER-1)/2; PW = NP*(L+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b; ignored when in_sq=1.
- in_sq  in  1  squaring mode: b limbs and b sums are copied from a.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_a_limbs  out  DATA_WIDTH  limb i of a at [i*L +: L]; limb 0 is the LSBs.
- out_b_limbs  out  DATA_WIDTH  limb i of b, same packing.
- out_a_psum  out  PW  pair sums of a, each L+1 bits.
- out_b_psum  out  PW  pair sums of b, same packing.
- out_tag  out  TAG_WIDTH  tag of the head entry.
- out_sq  out  1  in_sq of the head entry.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Limb split: limb i = operand[(i+1)*L-1 : i*L].
- Pair sums: psum for pair (i,j), i<j, is the zero-extended sum limb_i + limb_j, L+1 bits, no truncation.
- Pair order is lexicographic: (0,1),(0,2)...(0,K-1),(1,2)...(K-2,K-1). Pair k occupies [k*(L+1) +: L+1].
- Squaring mode: when in_sq=1, the stored b limbs equal the a limbs and the b psums equal the a psums. in_b is don't-care.
- Transfers:
  - Input transfer occurs on a rising edge with in_valid & in_ready.
  - Output transfer occurs on a rising edge with out_valid & out_ready.
- Buffer: 2-entry FIFO of computed results, with an occupancy counter cnt in 0..2.
  - in_ready = (cnt != 2) & ~rst. in_ready is a function of registered state only; there is no combinational path from out_ready to in_ready.
  - out_valid = (cnt != 0). Outputs always show the head entry and are held stable while out_valid & ~out_ready.
- Latency: a pair accepted at edge N is visible on the outputs (out_valid=1) after edge N, provided the buffer was empty. It is one cycle with an empty buffer.
- Throughput: one pair per cycle sustained while out_ready=1.
- Simultaneous push and pop:
  - cnt=1: cnt stays 1; the new entry becomes head on the next cycle, order preserved.
  - cnt=2: a push cannot occur because in_ready=0; the pop alone brings cnt to 1, and in_ready rises the following cycle.
- Ordering: strict FIFO; the tag and sq flag stay aligned with their data.
- Reset, applied on any cycle including mid-stream:
  - cnt=0, out_valid=0, in_ready=0 during the reset cycle and 1 on the first cycle after.
  - All data outputs, out_tag and out_sq = 0.
  - Buffered entries are discarded; no partial transfer survives.
- When out_valid=0, the outputs are the zeros held since reset or the last popped entry's stale values are not required; the implementation drives 0 on pop-to-empty.

Test Plan (DATA_WIDTH=72, KO_PARAMETER=4, L=18, NP=6):
- Pass-through: a=72'h1, b=all-ones, tag=3, out_ready=1 -> next cycle:
  - a limbs {0,0,0,1}; a psums (0,1),(0,2),(0,3)=1, others 0.
  - b limbs each 18'h3FFFF; b psums each 19'h7FFFE.
  - out_tag=3.
- Square mode: a=72'h3FFFF (limb0 only), b=72'h5, in_sq=1 -> out_b_limbs == out_a_limbs with limb0=18'h3FFFF; out_b_psum == out_a_psum; out_sq=1.
- Backpressure: out_ready=0, in_valid=1 with tags 1,2,3 on consecutive cycles -> tags 1 and 2 accepted; in_ready=0 after cnt=2; tag 3 held. Raise out_ready -> outputs in order 1,2,3 with no loss or duplicate.
- Streaming: 100 random pairs, out_ready=1 -> one output per cycle; each output matches the reference model's split and psums.
- Simultaneous push/pop at cnt=1 with random out_ready toggling -> order preserved; cnt never exceeds 2; in_ready never depends combinationally on out_ready.
- Reset mid-operation: fill to cnt=2, assert rst for 1 cycle -> out_valid=0, all outputs 0, in_ready=0 during reset and 1 after. The next accepted pair emerges as the first output.
